gifplayer_soc_debug_ocimem_arbiter: RTL and testbench
=====================================================

Name: gifplayer_soc_debug_ocimem_arbiter

Overview:
Sequences and arbitrates the single-port on-chip debug memory (OCI RAM) between two requesters. One is the JTAG debug slave's system-clock command strobes (take_action_ocimem_a/b, take_no_action_ocimem_a with jdo). The other is the CPU-side Avalon debug-memory slave. It sits in the Nios II debug module, between the debug-slave sysclk decoder outputs and the OCI RAM. It owns the JTAG auto-incrementing address pointer and returns JTAG read data on MonDReg/monitor_ready.

Parameters:
ADDR_W, 8, OCI RAM word-address width (depth 2^ADDR_W x 32).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jdo  in  38  JTAG command data, valid with any strobe
take_action_ocimem_a  in  1  one-cycle strobe: load JTAG address
take_action_ocimem_b  in  1  one-cycle strobe: JTAG write
take_no_action_ocimem_a  in  1  one-cycle strobe: JTAG read
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  CPU stall
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteenable  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, 1-cycle latency after address
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  JTAG op complete
jtag_overrun  out  1  sticky: JTAG strobe dropped

Behaviour:
- Reset: one clock, synchronous, active-high, as decided.
- Reset values: MonDReg=0, monitor_ready=0, jtag_overrun=0, ram_wren=0, avs_waitrequest=1, jaddr=0, FSM=IDLE, JTAG pending slot empty, last_grant=JTAG (so the CPU wins the first contention).
- JTAG decode. Priority when strobes coincide: ocimem_a > ocimem_b > no_action. Lower-priority strobes in the same cycle are dropped and set jtag_overrun.
  - take_action_ocimem_a: jaddr <= jdo[ADDR_W+2:3]; clears jtag_overrun; no RAM access; does not touch the pending slot.
  - take_action_ocimem_b: queues write of jdo[34:3], all byte enables set.
  - take_no_action_ocimem_a: queues read.
  - Queueing clears monitor_ready.
  - Strobe b or no_action while the slot is already pending: dropped; jtag_overrun <= 1.
- Arbiter FSM states: IDLE, CPU_RD, JTAG_RD.
  - IDLE: the CPU requests if avs_read|avs_write; JTAG requests if the slot is pending.
  - One requester: it is granted.
  - Both: grant goes to the requester != last_grant; last_grant updates on every grant.
  - Write grant: completes in the grant cycle (ram_wren=1, ram_addr/ram_wdata/ram_byteenable driven combinationally); stays in IDLE.
    - CPU write: avs_waitrequest=0 in the grant cycle.
    - JTAG write: slot cleared, jaddr+1, monitor_ready<=1.
  - Read grant: drive ram_addr, then go to CPU_RD or JTAG_RD.
  - CPU_RD: avs_readdata=ram_rdata, avs_waitrequest=0 for one cycle, then IDLE. CPU read latency is 2 cycles.
  - JTAG_RD: MonDReg<=ram_rdata, slot cleared, jaddr+1, monitor_ready<=1, then IDLE.
- avs_waitrequest is 1 in every cycle other than a CPU completion cycle.
- ram_wren is 0 outside write grants. ram_addr/ram_wdata/ram_byteenable are don't-care when ram_wren=0 and no read is issued.
- jaddr wraps 2^ADDR_W-1 -> 0.
- A JTAG strobe arriving in the cycle its predecessor completes is accepted (the slot frees first).
- Reset during CPU_RD/JTAG_RD: the op is aborted and the pending JTAG slot is discarded. The CPU master sees waitrequest=1 and re-presents its request after reset.

Test Plan:
- JTAG path: ocimem_a jdo[10:3]=0x10; ocimem_b jdo[34:3]=0xDEADBEEF; ocimem_a 0x10; no_action -> MonDReg=0xDEADBEEF, monitor_ready=1, jaddr=0x11.
- CPU byte write: preload 0xFFFFFFFF at 0x20; write 0x12345678 be=4'b0011 -> waitrequest low in cycle 1; read 0x20 -> waitrequest low in cycle 2, readdata=0xFFFF5678.
- Contention: after reset, CPU read and JTAG read both present in the same IDLE cycle -> CPU granted first, JTAG next. A second simultaneous pair -> JTAG granted first.
- Wrap: ocimem_a 0xFF, ocimem_b 0xA5A5A5A5 -> RAM[0xFF]=0xA5A5A5A5, jaddr=0x00.
- Overrun: hold CPU writes continuously so a JTAG write stays pending; issue no_action -> jtag_overrun=1, the read never executes. Issue ocimem_a -> jtag_overrun=0.
- Reset mid-read: assert reset in the CPU_RD cycle -> avs_waitrequest=1, ram_wren=0, FSM IDLE. The re-issued read returns correct data in 2 cycles.

Source files
------------

// File: rtl/gifplayer_soc_debug_ocimem_arbiter_if.sv
// Bus bundle between the OCI RAM arbiter, the CPU-side Avalon debug-memory slave
// and the single-port OCI RAM.
interface gifplayer_soc_debug_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wren;
  logic [3:0]        ram_byteenable;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest,
    output ram_addr, ram_wren, ram_byteenable, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest,
    input  ram_addr, ram_wren, ram_byteenable, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/gifplayer_soc_debug_ocimem_arbiter.sv
// Arbitrates the single-port OCI RAM between JTAG debug-slave strobes and the CPU
// Avalon debug-memory slave; owns the auto-incrementing JTAG address pointer.
//
// state   | meaning
// IDLE    | arbitrate; writes complete here, reads issue their address here
// CPU_RD  | RAM data for the CPU read is valid; release waitrequest
// JTAG_RD | RAM data for the JTAG read is valid; capture into MonDReg
module gifplayer_soc_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic        take_no_action_ocimem_a,
  gifplayer_soc_debug_ocimem_arbiter_if.slave bus,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        jtag_overrun
);

  typedef enum logic [1:0] {IDLE, CPU_RD, JTAG_RD} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] jaddr;
  logic              jpend, jpend_wr;
  logic [31:0]       jpend_data;
  logic              last_grant_cpu;

  logic cpu_req, grant_cpu, grant_jtag;
  logic jtag_done, slot_free;
  logic q_wr, q_rd, accept_wr, accept_rd, drop;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Arbitration: alternate on contention, grants only in IDLE and never under reset.
  always_comb begin
    cpu_req    = bus.avs_read | bus.avs_write;
    grant_cpu  = 1'b0;
    grant_jtag = 1'b0;
    if (!reset && state == IDLE) begin
      if (cpu_req && (!jpend || !last_grant_cpu)) grant_cpu = 1'b1;
      else if (jpend)                             grant_jtag = 1'b1;
    end
    jtag_done = (grant_jtag & jpend_wr) | (!reset && state == JTAG_RD);
    slot_free = !jpend | jtag_done;
  end

  // Strobe decode; the slot frees before a same-cycle strobe is considered.
  always_comb begin
    q_wr      = take_action_ocimem_b & ~take_action_ocimem_a;
    q_rd      = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    accept_wr = q_wr & slot_free;
    accept_rd = q_rd & slot_free;
    drop      = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
              | (take_action_ocimem_b & take_no_action_ocimem_a)
              | ((q_wr | q_rd) & ~slot_free);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_cpu && !bus.avs_write)  state_nxt = CPU_RD;
        else if (grant_jtag && !jpend_wr) state_nxt = JTAG_RD;
      end
      CPU_RD:  state_nxt = IDLE;
      JTAG_RD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.avs_waitrequest = 1'b1;
    bus.avs_readdata    = 32'h0;
    bus.ram_wren        = 1'b0;
    bus.ram_addr        = jaddr;
    bus.ram_wdata       = jpend_data;
    bus.ram_byteenable  = 4'hF;
    if (grant_cpu) begin
      bus.ram_addr       = bus.avs_address;
      bus.ram_wdata      = bus.avs_writedata;
      bus.ram_byteenable = bus.avs_byteenable;
      if (bus.avs_write) begin
        bus.ram_wren        = 1'b1;
        bus.avs_waitrequest = 1'b0;
      end
    end else if (grant_jtag) begin
      bus.ram_wren = jpend_wr;
    end
    if (!reset && state == CPU_RD) begin
      bus.avs_waitrequest = 1'b0;
      bus.avs_readdata    = bus.ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      jaddr          <= '0;
      jpend          <= 1'b0;
      jpend_wr       <= 1'b0;
      jpend_data     <= 32'h0;
      last_grant_cpu <= 1'b0;
      MonDReg        <= 32'h0;
      monitor_ready  <= 1'b0;
      jtag_overrun   <= 1'b0;
    end else begin
      if (grant_cpu)       last_grant_cpu <= 1'b1;
      else if (grant_jtag) last_grant_cpu <= 1'b0;

      if (state == JTAG_RD) MonDReg <= bus.ram_rdata;

      if (jtag_done) begin
        jpend         <= 1'b0;
        monitor_ready <= 1'b1;
      end

      // A fresh address load supersedes the post-access increment.
      if (take_action_ocimem_a) jaddr <= jdo[ADDR_W+2:3];
      else if (jtag_done)       jaddr <= jaddr + ADDR_ONE;

      if (accept_wr || accept_rd) begin
        jpend         <= 1'b1;
        jpend_wr      <= accept_wr;
        jpend_data    <= jdo[34:3];
        monitor_ready <= 1'b0;
      end

      if (drop)                      jtag_overrun <= 1'b1;
      else if (take_action_ocimem_a) jtag_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gifplayer_soc_debug_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter: a per-cycle vector table plus
// hand-written contention, wrap, overrun and reset-abort sequences.
module tb_gifplayer_soc_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        act_a, act_b, noact;
  logic [31:0] mon;
  logic        rdy, ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gifplayer_soc_debug_ocimem_arbiter_if #(.ADDR_W(8)) bus ();

  gifplayer_soc_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (act_a),
    .take_action_ocimem_b    (act_b),
    .take_no_action_ocimem_a (noact),
    .bus                     (bus),
    .MonDReg                 (mon),
    .monitor_ready           (rdy),
    .jtag_overrun            (ovr)
  );

  // OCI RAM model: byte-enabled write, 1-cycle read latency, preload port.
  logic [31:0] mem [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = 8'h0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.ram_wren)
      for (int i = 0; i < 4; i++)
        if (bus.ram_byteenable[i]) mem[bus.ram_addr][i*8 +: 8] <= bus.ram_wdata[i*8 +: 8];
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic        rst;
    logic [2:0]  js;     // {ocimem_a, ocimem_b, no_action}
    logic [31:0] jd;
    logic [1:0]  cop;    // {read, write}
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [1:0]  e_ww;   // {waitrequest, ram_wren}
    logic        c_ra;
    logic [7:0]  e_ra;
    logic [31:0] e_rd;
    logic [31:0] e_mon;
    logic [1:0]  e_ro;   // {monitor_ready, jtag_overrun}
    logic [7:0]  e_ja;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  function automatic logic [37:0] mkj(input logic [31:0] d);
    return {3'b000, d, 3'b000};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_in();
    reset              = 1'b0;
    act_a              = 1'b0;
    act_b              = 1'b0;
    noact              = 1'b0;
    jdo                = '0;
    bus.avs_read       = 1'b0;
    bus.avs_write      = 1'b0;
    bus.avs_address    = 8'h0;
    bus.avs_writedata  = 32'h0;
    bus.avs_byteenable = 4'h0;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle_in();
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  initial begin
    idle_in();
    reset = 1'b1;
    preload(8'h00, 32'h00C0FFEE);
    preload(8'h01, 32'h13579BDF);
    preload(8'h20, 32'hFFFFFFFF);

    //           rst   js      jd            cop    addr   wd            be       ww     cra   ra     rdata         mon           ro     ja
    vt[0]  = '{1'b1, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'h0,        2'b00, 8'h00};
    vt[1]  = '{1'b0, 3'b100, 32'h10,       2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'h0,        2'b00, 8'h00};
    vt[2]  = '{1'b0, 3'b010, 32'hDEADBEEF, 2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'h0,        2'b00, 8'h10};
    vt[3]  = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b11, 1'b1, 8'h10, 32'h0,        32'h0,        2'b00, 8'h10};
    vt[4]  = '{1'b0, 3'b100, 32'h10,       2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'h0,        2'b10, 8'h11};
    vt[5]  = '{1'b0, 3'b001, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'h0,        2'b10, 8'h10};
    vt[6]  = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b1, 8'h10, 32'h0,        32'h0,        2'b00, 8'h10};
    vt[7]  = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'h0,        2'b00, 8'h10};
    vt[8]  = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 2'b10, 8'h11};
    vt[9]  = '{1'b0, 3'b000, 32'h0,        2'b01, 8'h20, 32'h12345678, 4'b0011, 2'b01, 1'b1, 8'h20, 32'h0,        32'hDEADBEEF, 2'b10, 8'h11};
    vt[10] = '{1'b0, 3'b000, 32'h0,        2'b10, 8'h20, 32'h0,        4'hF,    2'b10, 1'b1, 8'h20, 32'h0,        32'hDEADBEEF, 2'b10, 8'h11};
    vt[11] = '{1'b0, 3'b000, 32'h0,        2'b10, 8'h20, 32'h0,        4'hF,    2'b00, 1'b0, 8'h00, 32'hFFFF5678, 32'hDEADBEEF, 2'b10, 8'h11};
    vt[12] = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 2'b10, 8'h11};
    vt[13] = '{1'b0, 3'b100, 32'h30,       2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 2'b10, 8'h11};
    vt[14] = '{1'b0, 3'b010, 32'h11111111, 2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 2'b10, 8'h30};
    vt[15] = '{1'b0, 3'b010, 32'h22222222, 2'b00, 8'h00, 32'h0,        4'h0,    2'b11, 1'b1, 8'h30, 32'h0,        32'hDEADBEEF, 2'b00, 8'h30};
    vt[16] = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b11, 1'b1, 8'h31, 32'h0,        32'hDEADBEEF, 2'b00, 8'h31};
    vt[17] = '{1'b0, 3'b000, 32'h0,        2'b00, 8'h00, 32'h0,        4'h0,    2'b10, 1'b0, 8'h00, 32'h0,        32'hDEADBEEF, 2'b10, 8'h32};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset              = vt[i].rst;
      {act_a, act_b, noact} = vt[i].js;
      jdo                = mkj(vt[i].jd);
      {bus.avs_read, bus.avs_write} = vt[i].cop;
      bus.avs_address    = vt[i].addr;
      bus.avs_writedata  = vt[i].wd;
      bus.avs_byteenable = vt[i].be;
      #1;
      chk($sformatf("v%0d waitrequest", i), bus.avs_waitrequest, vt[i].e_ww[1]);
      chk($sformatf("v%0d ram_wren", i), bus.ram_wren, vt[i].e_ww[0]);
      if (vt[i].c_ra) chk($sformatf("v%0d ram_addr", i), bus.ram_addr, vt[i].e_ra);
      if (vt[i].cop[1] && !vt[i].e_ww[1])
        chk($sformatf("v%0d readdata", i), bus.avs_readdata, vt[i].e_rd);
      chk($sformatf("v%0d MonDReg", i), mon, vt[i].e_mon);
      chk($sformatf("v%0d monitor_ready", i), rdy, vt[i].e_ro[1]);
      chk($sformatf("v%0d jtag_overrun", i), ovr, vt[i].e_ro[0]);
      chk($sformatf("v%0d jaddr", i), dut.jaddr, vt[i].e_ja);
    end
    chk("ram 0x10", mem[8'h10], 32'hDEADBEEF);
    chk("ram 0x20", mem[8'h20], 32'hFFFF5678);
    chk("ram 0x30", mem[8'h30], 32'h11111111);
    chk("ram 0x31", mem[8'h31], 32'h22222222);

    // Contention right after reset: CPU first, then JTAG.
    cyc(); reset = 1'b1;
    cyc(); noact = 1'b1;
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h20; #1;
    chk("cont1 cpu grant wait", bus.avs_waitrequest, 1'b1);
    chk("cont1 cpu grant addr", bus.ram_addr, 8'h20);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h20; #1;
    chk("cont1 cpu done wait", bus.avs_waitrequest, 1'b0);
    chk("cont1 cpu readdata", bus.avs_readdata, 32'hFFFF5678);
    cyc(); #1;
    chk("cont1 jtag grant addr", bus.ram_addr, 8'h00);
    chk("cont1 jtag pending ready", rdy, 1'b0);
    cyc(); #1;
    cyc(); #1;
    chk("cont1 jtag MonDReg", mon, 32'h00C0FFEE);
    chk("cont1 jtag ready", rdy, 1'b1);

    // CPU-only write leaves last grant with the CPU, so JTAG wins the next pair.
    cyc(); bus.avs_write = 1'b1; bus.avs_address = 8'h50;
    bus.avs_writedata = 32'h5555AAAA; bus.avs_byteenable = 4'hF; #1;
    chk("cont2 cpu write wait", bus.avs_waitrequest, 1'b0);
    cyc(); noact = 1'b1;
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h50; #1;
    chk("cont2 jtag first wait", bus.avs_waitrequest, 1'b1);
    chk("cont2 jtag first addr", bus.ram_addr, 8'h01);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h50; #1;
    chk("cont2 jtag_rd wait", bus.avs_waitrequest, 1'b1);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h50; #1;
    chk("cont2 cpu grant wait", bus.avs_waitrequest, 1'b1);
    chk("cont2 cpu grant addr", bus.ram_addr, 8'h50);
    chk("cont2 jtag MonDReg", mon, 32'h13579BDF);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h50; #1;
    chk("cont2 cpu done wait", bus.avs_waitrequest, 1'b0);
    chk("cont2 cpu readdata", bus.avs_readdata, 32'h5555AAAA);

    // Address wrap 0xFF -> 0x00.
    cyc(); act_a = 1'b1; jdo = mkj(32'hFF);
    cyc(); act_b = 1'b1; jdo = mkj(32'hA5A5A5A5);
    cyc(); #1;
    chk("wrap wren", bus.ram_wren, 1'b1);
    chk("wrap addr", bus.ram_addr, 8'hFF);
    cyc(); #1;
    chk("wrap ram 0xFF", mem[8'hFF], 32'hA5A5A5A5);
    chk("wrap jaddr", dut.jaddr, 8'h00);

    // Overrun: read strobe while a JTAG write is still pending behind the CPU.
    cyc(); act_b = 1'b1; jdo = mkj(32'h77777777);
    cyc(); bus.avs_write = 1'b1; bus.avs_address = 8'h40;
    bus.avs_writedata = 32'h0BADF00D; bus.avs_byteenable = 4'hF; noact = 1'b1; #1;
    chk("ovr cpu wins wait", bus.avs_waitrequest, 1'b0);
    chk("ovr cpu wins addr", bus.ram_addr, 8'h40);
    chk("ovr not yet set", ovr, 1'b0);
    cyc(); bus.avs_write = 1'b1; bus.avs_address = 8'h40;
    bus.avs_writedata = 32'h0BADF00D; bus.avs_byteenable = 4'hF; #1;
    chk("ovr sticky set", ovr, 1'b1);
    chk("ovr jtag write wait", bus.avs_waitrequest, 1'b1);
    chk("ovr jtag write addr", bus.ram_addr, 8'h00);
    cyc(); bus.avs_write = 1'b1; bus.avs_address = 8'h40;
    bus.avs_writedata = 32'h0BADF00D; bus.avs_byteenable = 4'hF; #1;
    chk("ovr cpu second wait", bus.avs_waitrequest, 1'b0);
    cyc(); #1;
    chk("ovr ram 0x00", mem[8'h00], 32'h77777777);
    chk("ovr MonDReg kept", mon, 32'h13579BDF);
    cyc(); #1;
    chk("ovr no read wren", bus.ram_wren, 1'b0);
    chk("ovr no read ready", rdy, 1'b1);
    cyc(); act_a = 1'b1; jdo = mkj(32'h05);
    cyc(); #1;
    chk("ovr cleared", ovr, 1'b0);

    // Reset during CPU_RD aborts the read and drops a queued JTAG read.
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h20; noact = 1'b1; #1;
    chk("rst grant wait", bus.avs_waitrequest, 1'b1);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h20; reset = 1'b1; #1;
    chk("rst cpu_rd wait", bus.avs_waitrequest, 1'b1);
    chk("rst cpu_rd wren", bus.ram_wren, 1'b0);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h20; #1;
    chk("rst reissue wait", bus.avs_waitrequest, 1'b1);
    chk("rst MonDReg", mon, 32'h0);
    cyc(); bus.avs_read = 1'b1; bus.avs_address = 8'h20; #1;
    chk("rst reissue done", bus.avs_waitrequest, 1'b0);
    chk("rst reissue data", bus.avs_readdata, 32'hFFFF5678);
    cyc(); #1;
    cyc(); #1;
    chk("rst slot discarded", rdy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
